// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared helpers for the N-to-2^N scan decoder
// Purpose: inactive-word and one-hot pattern builders (32-bit wide, callers
//          truncate to 2^N) plus a minimum-1-bit clog2 for the prescaler width.
// Ports:   none (package)
package decoder_pkg;

  localparam int MAX_N = 5;
  localparam int MAX_W = 32;

  // All lines inactive; callers cast down to their own 2^N width.
  function automatic logic [MAX_W-1:0] inact_word(input logic active_low);
    return active_low ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
  endfunction

  // Inactive word with exactly bit idx inverted.
  function automatic logic [MAX_W-1:0] onehot_pattern(input logic [MAX_N-1:0] idx,
                                                      input logic active_low);
    logic [MAX_W-1:0] v;
    v      = inact_word(active_low);
    v[idx] = ~v[idx];
    return v;
  endfunction

  // ceil(log2(v)), but never less than 1 so a DIV=1 counter still has a bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - DIV prescaler and scan index counter with SCAN_LAST wrap
// Purpose: counts DIV clocks per index step and walks the index 0..SCAN_LAST.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clear         restart: index and prescaler back to 0
//   i_enable        count this cycle; when low (and no clear) the prescaler
//                   phase is reset while the index is held
//   o_idx_next      index value that will be registered at this edge
//   o_tick          index advances at this edge
//   o_wrap          index advances from SCAN_LAST to 0 at this edge
module scan_prescaler
  import decoder_pkg::*;
#(
  parameter int N         = 2,
  parameter int DIV       = 4,
  parameter int SCAN_LAST = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_enable,
  output logic [N-1:0] o_idx_next,
  output logic         o_tick,
  output logic         o_wrap
);

  localparam int            PW       = clog2_min1(DIV);
  localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);
  localparam logic [N-1:0]  IDX_LAST = N'(SCAN_LAST);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_cnt_next;
  logic [N-1:0]  r_idx;
  logic [N-1:0]  w_idx_next;
  logic          w_tick;
  logic          w_wrap;

  always_comb begin
    w_tick     = i_enable && (r_cnt == CNT_LAST);
    w_wrap     = w_tick && (r_idx == IDX_LAST);
    w_cnt_next = '0;
    w_idx_next = r_idx;
    if (i_clear) begin
      w_idx_next = '0;
    end else if (i_enable) begin
      if (w_tick) begin
        // Explicit wrap: the index never runs through 2^N unless SCAN_LAST
        // is the top value.
        w_idx_next = w_wrap ? '0 : r_idx + 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_idx <= w_idx_next;
    end
  end

  assign o_idx_next = w_idx_next;
  assign o_tick     = w_tick;
  assign o_wrap     = w_wrap;

endmodule

// File: rtl/decoder_nx_scan.sv
// rtl/decoder_nx_scan.sv - registered N-to-2^N decoder with auto-scan mode
// Purpose: direct decode of i_sel or prescaled scan 0..SCAN_LAST onto one-hot
//          lines of selectable polarity; all outputs registered.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            low: all lines inactive, index held
//   i_mode          0: direct decode of i_sel, 1: auto-scan
//   i_sel           direct-mode select (N bits)
//   o_y             decoded lines (2^N bits)
//   o_cur_idx       index currently shown on o_y
//   o_wrap          one-cycle pulse when the scan index wraps to 0
module decoder_nx_scan
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int DIV        = 4,
  parameter int SCAN_LAST  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [N-1:0]      i_sel,
  output logic [(1<<N)-1:0] o_y,
  output logic [N-1:0]      o_cur_idx,
  output logic              o_wrap
);

  localparam int          W     = 1 << N;
  localparam logic        AL    = (ACTIVE_LOW != 0);
  localparam logic [W-1:0] INACT = W'(inact_word(AL));

  typedef enum logic {
    S_IDLE_SCAN = 1'b0,
    S_RUN       = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         w_clear;
  logic         w_enable;
  logic [N-1:0] w_idx_next;
  logic         w_tick;
  logic         w_scan_wrap;

  logic [W-1:0] r_y;
  logic [N-1:0] r_cur;
  logic         r_wrap;
  logic [W-1:0] w_y_next;
  logic [N-1:0] w_cur_next;
  logic         w_wrap_next;

  scan_prescaler #(
    .N         (N),
    .DIV       (DIV),
    .SCAN_LAST (SCAN_LAST)
  ) u_prescaler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .o_idx_next (w_idx_next),
    .o_tick     (w_tick),
    .o_wrap     (w_scan_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE_SCAN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Scan sequencing. Any cycle that is not scan drops back to IDLE_SCAN so
  // the next scan cycle is an entry and restarts from index 0. Direct mode
  // also clears the index; en=0 leaves it alone.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_enable     = 1'b0;
    if (i_en && i_mode) begin
      if (r_state == S_IDLE_SCAN) begin
        w_clear      = 1'b1;
        w_state_next = S_RUN;
      end else begin
        w_enable = 1'b1;
      end
    end else begin
      w_state_next = S_IDLE_SCAN;
      w_clear      = i_en;
    end
  end

  // Output mux; en has priority over mode.
  always_comb begin
    w_y_next    = r_y;
    w_cur_next  = r_cur;
    w_wrap_next = 1'b0;
    if (!i_en) begin
      w_y_next = INACT;
    end else if (!i_mode) begin
      w_y_next   = W'(onehot_pattern(MAX_N'(i_sel), AL));
      w_cur_next = i_sel;
    end else if (w_clear || w_tick) begin
      // Only entry and index steps change the lines; between ticks they hold.
      w_y_next    = W'(onehot_pattern(MAX_N'(w_idx_next), AL));
      w_cur_next  = w_idx_next;
      w_wrap_next = w_scan_wrap;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y    <= INACT;
      r_cur  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_y    <= w_y_next;
      r_cur  <= w_cur_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign o_y       = r_y;
  assign o_cur_idx = r_cur;
  assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_nx_scan.sv
// tb/tb_decoder_nx_scan.sv - self-checking bench for decoder_nx_scan
module tb_decoder_nx_scan;

  logic       clk;
  logic       rst_n;
  logic       en_a, mode_a;
  logic [1:0] sel_a;
  logic [3:0] y_a;
  logic [1:0] cur_a;
  logic       wrap_a;
  logic       en_b, mode_b;
  logic [2:0] sel_b;
  logic [7:0] y_b;
  logic [2:0] cur_b;
  logic       wrap_b;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state per DUT (0: A, 1: B)
  bit m_scan[2];
  int m_t[2];
  int m_cur[2];

  logic [31:0] ey_a, ey_b;
  int          ei_a, ei_b;
  bit          ew_a, ew_b;

  decoder_nx_scan #(.N(2), .ACTIVE_LOW(1), .DIV(4), .SCAN_LAST(3)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_mode(mode_a), .i_sel(sel_a),
    .o_y(y_a), .o_cur_idx(cur_a), .o_wrap(wrap_a)
  );

  decoder_nx_scan #(.N(3), .ACTIVE_LOW(0), .DIV(1), .SCAN_LAST(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_mode(mode_b), .i_sel(sel_b),
    .o_y(y_b), .o_cur_idx(cur_b), .o_wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] inact(input int w, input bit al);
    return al ? 32'((64'd1 << w) - 64'd1) : 32'd0;
  endfunction

  function automatic logic [31:0] pat(input int w, input bit al, input int i);
    logic [31:0] v;
    v    = inact(w, al);
    v[i] = ~v[i];
    return v;
  endfunction

  // Scan position is time since entry: index = (t / DIV) mod (SCAN_LAST+1),
  // wrap whenever a full period has elapsed.
  task automatic model_step(input int id, input int w, input bit al, input int div,
                            input int last, input bit en, input bit mode, input int sel,
                            output logic [31:0] ey, output int ei, output bit ew);
    int idx;
    ew = 1'b0;
    if (!en) begin
      ey = inact(w, al);
      m_scan[id] = 1'b0;
    end else if (!mode) begin
      ey = pat(w, al, sel);
      m_cur[id] = sel;
      m_scan[id] = 1'b0;
    end else begin
      if (!m_scan[id]) begin
        m_scan[id] = 1'b1;
        m_t[id] = 0;
      end else begin
        m_t[id]++;
      end
      idx = (m_t[id] / div) % (last + 1);
      ey = pat(w, al, idx);
      ew = (m_t[id] > 0) && (m_t[id] % (div * (last + 1)) == 0);
      m_cur[id] = idx;
    end
    ei = m_cur[id];
  endtask

  task automatic cycle(input bit ea, input bit ma, input int sa,
                       input bit eb, input bit mb, input int sb);
    en_a = ea; mode_a = ma; sel_a = 2'(sa);
    en_b = eb; mode_b = mb; sel_b = 3'(sb);
    model_step(0, 4, 1'b1, 4, 3, ea, ma, sa, ey_a, ei_a, ew_a);
    model_step(1, 8, 1'b0, 1, 4, eb, mb, sb, ey_b, ei_b, ew_b);
    @(posedge clk);
    #1;
    chk("a_y",    32'(y_a),    ey_a);
    chk("a_idx",  32'(cur_a),  32'(ei_a));
    chk("a_wrap", 32'(wrap_a), 32'(ew_a));
    chk("b_y",    32'(y_b),    ey_b);
    chk("b_idx",  32'(cur_b),  32'(ei_b));
    chk("b_wrap", 32'(wrap_b), 32'(ew_b));
  endtask

  typedef struct {
    bit         en;
    bit         mode;
    int         sel;
    logic [3:0] ey;
    logic [1:0] ei;
    bit         ew;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int wraps_a, wraps_b, hits_20;
    bit ea, ma, eb, mb;

    rst_n = 1'b0;
    en_a = 0; mode_a = 0; sel_a = 0;
    en_b = 0; mode_b = 0; sel_b = 0;
    m_scan = '{0, 0}; m_t = '{0, 0}; m_cur = '{0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_y",    32'(y_a),    32'hF);
    chk("rst_a_idx",  32'(cur_a),  32'd0);
    chk("rst_a_wrap", 32'(wrap_a), 32'd0);
    chk("rst_b_y",    32'(y_b),    32'h00);
    #3 rst_n = 1'b1;

    // Direct decode, enable gating, en priority, scan entry and first step.
    vecs.push_back('{1, 0, 0, 4'b1110, 2'd0, 0});
    vecs.push_back('{1, 0, 1, 4'b1101, 2'd1, 0});
    vecs.push_back('{1, 0, 2, 4'b1011, 2'd2, 0});
    vecs.push_back('{1, 0, 3, 4'b0111, 2'd3, 0});
    vecs.push_back('{0, 0, 2, 4'b1111, 2'd3, 0});
    vecs.push_back('{1, 0, 2, 4'b1011, 2'd2, 0});
    vecs.push_back('{0, 1, 3, 4'b1111, 2'd2, 0});
    vecs.push_back('{1, 1, 3, 4'b1110, 2'd0, 0});
    vecs.push_back('{1, 1, 0, 4'b1110, 2'd0, 0});
    vecs.push_back('{1, 1, 0, 4'b1110, 2'd0, 0});
    vecs.push_back('{1, 1, 0, 4'b1110, 2'd0, 0});
    vecs.push_back('{1, 1, 0, 4'b1101, 2'd1, 0});
    vecs.push_back('{1, 0, 3, 4'b0111, 2'd3, 0});
    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].mode, vecs[i].sel, 1'b0, 1'b0, 0);
      chk($sformatf("tbl%0d_y", i),    32'(y_a),    32'(vecs[i].ey));
      chk($sformatf("tbl%0d_idx", i),  32'(cur_a),  32'(vecs[i].ei));
      chk($sformatf("tbl%0d_wrap", i), 32'(wrap_a), 32'(vecs[i].ew));
    end

    // Long scan on both: A wraps at k=16,32; B every 5 clocks, never 0x20.
    wraps_a = 0; wraps_b = 0; hits_20 = 0;
    for (int k = 0; k < 33; k++) begin
      cycle(1'b1, 1'b1, 0, 1'b1, 1'b1, 7);
      if (wrap_a) wraps_a++;
      if (wrap_b) wraps_b++;
      if (y_b == 8'h20) hits_20++;
    end
    chk("scan_a_wraps", 32'(wraps_a), 32'd2);
    chk("scan_b_wraps", 32'(wraps_b), 32'd6);
    chk("scan_b_no20",  32'(hits_20), 32'd0);

    // Mode switch mid-scan at index 2, then re-entry restarts prescaler.
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, 0, 1'b1, 1'b1, 0);
    chk("ms_at2_y",   32'(y_a),   32'b1011);
    chk("ms_at2_idx", 32'(cur_a), 32'd2);
    cycle(1'b1, 1'b0, 1, 1'b1, 1'b1, 0);
    chk("ms_dir_y",   32'(y_a),   32'b1101);
    chk("ms_dir_idx", 32'(cur_a), 32'd1);
    cycle(1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
    chk("ms_re_y",    32'(y_a),   32'b1110);
    chk("ms_re_idx",  32'(cur_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
      chk("ms_hold_y", 32'(y_a), 32'b1110);
    end
    cycle(1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
    chk("ms_step_y", 32'(y_a), 32'b1101);

    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_a_y",   32'(y_a),   32'hF);
    chk("arst_a_idx", 32'(cur_a), 32'd0);
    chk("arst_b_y",   32'(y_b),   32'h00);
    chk("arst_b_idx", 32'(cur_b), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_a_y", 32'(y_a), 32'hF);
    rst_n = 1'b1;
    m_scan = '{0, 0}; m_cur = '{0, 0};

    // Randomized run with sticky mode and occasional enable drops.
    ea = 1; ma = 1; eb = 1; mb = 1;
    for (int k = 0; k < 400; k++) begin
      ea = ($urandom_range(0, 15) != 0);
      eb = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) ma = ~ma;
      if ($urandom_range(0, 19) == 0) mb = ~mb;
      cycle(ea, ma, int'($urandom_range(0, 3)), eb, mb, int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
